// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP sequencer
// for a small RISC-V subset, with a sticky illegal-opcode trap and a retire counter.
`default_nettype none

module multicycle_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [1:0]  imm_sel,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        illegal_instr,
    output logic [31:0] instret
);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  opcode_q;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;

    logic w_is_load, w_is_opimm, w_is_store, w_is_branch, w_is_op, w_legal;
    logic w_unused;

    assign w_is_load   = (opcode_q == c_OPC_LOAD);
    assign w_is_opimm  = (opcode_q == c_OPC_OPIMM);
    assign w_is_store  = (opcode_q == c_OPC_STORE);
    assign w_is_branch = (opcode_q == c_OPC_BRANCH);
    assign w_is_op     = (opcode_q == c_OPC_OP);
    assign w_legal     = w_is_load | w_is_opimm | w_is_store | w_is_branch | w_is_op;
    assign w_unused    = ^instr[31:7];

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        imm_sel   = 2'd3;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = w_legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (w_is_branch) begin
                    pc_write = branch_cond;
                    pc_src   = branch_cond;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_store;
                if (mem_ready) begin
                    retire  = w_is_store;
                    state_d = w_is_store ? S_FETCH : S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                wb_sel    = w_is_load;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Datapath selects follow the latched opcode only while an instruction is in flight.
        if (state_q == S_DECODE || state_q == S_EXECUTE ||
            state_q == S_MEM || state_q == S_WRITEBACK) begin
            if (w_is_load || w_is_opimm) begin
                imm_sel   = 2'd0;
                alu_src_b = 1'b1;
            end else if (w_is_store) begin
                imm_sel   = 2'd1;
                alu_src_b = 1'b1;
            end else if (w_is_branch) begin
                imm_sel   = 2'd2;
            end
        end

        if (rst) begin
            state_d   = S_FETCH;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            imm_sel   = 2'd3;
            alu_src_b = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= 7'd0;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                opcode_q <= instr[6:0];
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign illegal_instr = illegal_q;
    assign instret       = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit.
`default_nettype none

module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_cond;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src;
    logic [1:0]  imm_sel;
    logic        alu_src_b, reg_write, wb_sel, illegal_instr;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_cond  (branch_cond),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .imm_sel      (imm_sel),
        .alu_src_b    (alu_src_b),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .illegal_instr(illegal_instr),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          fwait;
        int          mwait;
        logic        bc;
        logic        noise;
        int          cyc;
        logic [1:0]  imm;
        logic        alub;
        int          mreq;
        int          we;
        int          rw;
        logic        wbs;
        int          br;
        int          pcw;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {mem_req, mem_we, ir_write, pc_write, reg_write};
    endfunction

    // Runs one instruction from FETCH until instret moves, modelling memory wait states.
    task automatic run_vec(input vec_t v, input int id);
        int cyc = 0, reqcnt = 0;
        int n_irw = 0, n_mreq = 0, n_we = 0, n_rw = 0, n_br = 0, n_pcw = 0, n_err = 0, n_viol = 0;
        bit fetched = 0, done = 0, was_fetched;
        logic wbs = 1'b0;
        logic [31:0] start = instret;
        instr       = v.instr;
        branch_cond = v.bc;
        while (!done && cyc < 30) begin
            #1;
            if (mem_req) begin
                mem_ready = (reqcnt == (fetched ? v.mwait : v.fwait));
                reqcnt++;
            end else begin
                mem_ready = v.noise;
            end
            #1;
            cyc++;
            was_fetched = fetched;
            if (!was_fetched) begin
                if (imm_sel !== 2'd3 || alu_src_b !== 1'b0) n_err++;
            end else begin
                if (imm_sel !== v.imm || alu_src_b !== v.alub) n_err++;
                if (mem_req) n_mreq++;
            end
            if (ir_write) begin
                n_irw++;
                fetched = 1;
                reqcnt  = 0;
            end
            if (mem_we) n_we++;
            if (reg_write) begin
                n_rw++;
                wbs = wb_sel;
            end
            if (pc_write) n_pcw++;
            if (pc_write && pc_src) n_br++;
            if (mem_we && !mem_req) n_viol++;
            @(posedge clk);
            #1;
            if (instret !== start) done = 1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        chk($sformatf("v%0d_retired", id), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_cycles", id), cyc, v.cyc);
        chk($sformatf("v%0d_instret", id), instret, start + 32'd1);
        chk($sformatf("v%0d_ir_write", id), n_irw, 1);
        chk($sformatf("v%0d_sel_errs", id), n_err, 0);
        chk($sformatf("v%0d_mem_req", id), n_mreq, v.mreq);
        chk($sformatf("v%0d_mem_we", id), n_we, v.we);
        chk($sformatf("v%0d_reg_write", id), n_rw, v.rw);
        chk($sformatf("v%0d_wb_sel", id), {31'd0, wbs}, {31'd0, v.wbs});
        chk($sformatf("v%0d_br_taken", id), n_br, v.br);
        chk($sformatf("v%0d_pc_write", id), n_pcw, v.pcw);
        chk($sformatf("v%0d_we_wo_req", id), n_viol, 0);
        #1;
        chk($sformatf("v%0d_next_fetch", id), {27'd0, strobes(), imm_sel}, {27'd0, 5'b10000, 2'd3});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] saved;
        //            instr        fw mw bc    nz    cyc imm  ab    mreq we rw wbs   br pcw
        vecs[0] = '{32'h00500093, 0, 0, 1'b0, 1'b0, 4, 2'd0, 1'b1, 0, 0, 1, 1'b0, 0, 1};
        vecs[1] = '{32'h0000A103, 0, 2, 1'b0, 1'b0, 7, 2'd0, 1'b1, 3, 0, 1, 1'b1, 0, 1};
        vecs[2] = '{32'h0020A223, 0, 0, 1'b0, 1'b0, 4, 2'd1, 1'b1, 1, 1, 0, 1'b0, 0, 1};
        vecs[3] = '{32'h00000463, 0, 0, 1'b1, 1'b0, 3, 2'd2, 1'b0, 0, 0, 0, 1'b0, 1, 2};
        vecs[4] = '{32'h00000463, 0, 0, 1'b0, 1'b0, 3, 2'd2, 1'b0, 0, 0, 0, 1'b0, 0, 1};
        vecs[5] = '{32'h002081B3, 2, 0, 1'b0, 1'b0, 6, 2'd3, 1'b0, 0, 0, 1, 1'b0, 0, 1};
        vecs[6] = '{32'h0020A223, 1, 1, 1'b0, 1'b0, 6, 2'd1, 1'b1, 2, 2, 0, 1'b0, 0, 1};
        vecs[7] = '{32'h0000A103, 0, 0, 1'b0, 1'b0, 5, 2'd0, 1'b1, 1, 0, 1, 1'b1, 0, 1};
        vecs[8] = '{32'h00500093, 0, 0, 1'b1, 1'b1, 4, 2'd0, 1'b1, 0, 0, 1, 1'b0, 0, 1};

        rst         = 1'b1;
        instr       = 32'h00500093;
        mem_ready   = 1'b1;
        branch_cond = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_strobes", {27'd0, strobes()}, 32'd0);
        chk("rst_pc_src_wb", {30'd0, pc_src, wb_sel}, 32'd0);
        chk("rst_imm_sel", {30'd0, imm_sel}, 32'd3);
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
        mem_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Illegal opcode: trap after DECODE, sticky until reset.
        saved       = instret;
        instr       = 32'hFFFFFFFF;
        branch_cond = 1'b0;
        #1 mem_ready = 1'b1;
        #1 chk("trap_fetch_irw", {31'd0, ir_write}, 32'd1);
        @(negedge clk);
        #1 mem_ready = 1'b1;
        #1;
        chk("trap_decode_strobes", {27'd0, strobes()}, 32'd0);
        chk("trap_decode_imm", {30'd0, imm_sel}, 32'd3);
        chk("trap_decode_flag", {31'd0, illegal_instr}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 mem_ready = i[0];
            #1;
            chk($sformatf("trap%0d_flag", i), {31'd0, illegal_instr}, 32'd1);
            chk($sformatf("trap%0d_strobes", i), {27'd0, strobes(), imm_sel}, {27'd0, 5'd0, 2'd3});
            chk($sformatf("trap%0d_instret", i), instret, saved);
        end
        mem_ready = 1'b1;
        rst = 1'b1;
        #1 chk("trap_rst_strobes", {27'd0, strobes()}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("trap_clr_flag", {31'd0, illegal_instr}, 32'd0);
        chk("trap_clr_instret", instret, 32'd0);
        chk("trap_clr_fetch", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        run_vec(vecs[0], 20);

        // Reset during a MEM wait.
        instr = 32'h0000A103;
        #1 mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("mid_mem_req", {30'd0, mem_req, mem_we}, 32'd2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_rst_out", {27'd0, strobes(), imm_sel}, {27'd0, 5'd0, 2'd3});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_after_fetch", {27'd0, strobes(), imm_sel}, {27'd0, 5'b10000, 2'd3});
        chk("mid_after_instret", instret, 32'd0);
        @(negedge clk);

        // Counter wrap.
        force dut.instret_q = 32'hFFFFFFFF;
        @(posedge clk);
        #1 release dut.instret_q;
        @(negedge clk);
        chk("wrap_preset", instret, 32'hFFFFFFFF);
        run_vec(vecs[0], 30);
        chk("wrap_zero", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr  input  32  instruction bus, valid in the cycle mem_ready is high during FETCH.
REQ-005 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-006 branch_cond  input  1  comparator result for the instruction held in IR.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  memory write enable (store data phase).
REQ-009 ir_write  output  1  latch instr into IR.
REQ-010 pc_write  output  1  update PC (PC+4 in FETCH, branch target in EXECUTE).
REQ-011 pc_src  output  1  0 = PC+4, 1 = branch target.
REQ-012 imm_sel  output  2  immediate format: 0 I, 1 S, 2 B, 3 none.
REQ-013 alu_src_b  output  1  0 = register rs2, 1 = immediate.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 wb_sel  output  1  0 = ALU result, 1 = load data.
REQ-016 illegal_instr  output  1  sticky trap flag.
REQ-017 instret  output  32  retired-instruction counter.

Function
REQ-018 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM, WRITEBACK and TRAP.
REQ-019 The block SHALL latch opcode = IR[6:0] when ir_write is high and decode only from that latched copy.
REQ-020 Legal opcodes: LOAD 0000011, OP-IMM 0010011, STORE 0100011, BRANCH 1100011, OP 0110011; every other opcode is illegal.
REQ-021 FETCH: mem_req=1, mem_we=0; hold state while mem_ready=0; when mem_ready=1, assert ir_write=1, pc_write=1, pc_src=0 in that cycle and move to DECODE.
REQ-022 DECODE: one cycle, no strobes; a legal opcode moves to EXECUTE, an illegal opcode moves to TRAP.
REQ-023 imm_sel SHALL be driven from the latched opcode in DECODE through WRITEBACK: LOAD/OP-IMM 0, STORE 1, BRANCH 2, OP 3; it SHALL be 3 in FETCH and TRAP.
REQ-024 alu_src_b SHALL be 1 for LOAD, OP-IMM and STORE and 0 for OP and BRANCH, with the same state qualification as imm_sel.
REQ-025 EXECUTE transitions: OP or OP-IMM goes to WRITEBACK; LOAD or STORE goes to MEM; BRANCH goes to FETCH.
REQ-026 EXECUTE for BRANCH: assert pc_write=1 and pc_src=1 only if branch_cond=1; otherwise no PC write (PC+4 was already applied in FETCH).
REQ-027 MEM: mem_req=1, and mem_we=1 for STORE only; hold state while mem_ready=0; on mem_ready, LOAD goes to WRITEBACK and STORE goes to FETCH.
REQ-028 WRITEBACK: reg_write=1 for exactly one cycle; wb_sel=1 for LOAD and 0 otherwise; then go to FETCH.
REQ-029 mem_we SHALL never be high unless mem_req is high; reg_write SHALL be high only in WRITEBACK.
REQ-030 Each instruction SHALL retire on its final-state exit: WRITEBACK to FETCH, STORE MEM to FETCH, or BRANCH EXECUTE to FETCH.
REQ-031 instret SHALL increment by 1 on each retire and wrap from 0xFFFFFFFF to 0x00000000.
REQ-032 TRAP: illegal_instr=1, all strobes 0, no retire; stay in TRAP until rst.
REQ-033 Latency with zero-wait memory (mem_ready high in the first request cycle): OP/OP-IMM 4 cycles, LOAD 5, STORE 4, BRANCH 3; each wait cycle adds 1.
REQ-034 A mem_ready pulse outside FETCH or MEM SHALL be ignored.

Reset
REQ-035 When rst=1 at a clock edge, from any state including mid-wait in FETCH or MEM, the next state SHALL be FETCH.
REQ-036 On that same reset edge, instret=0, illegal_instr=0 and the latched opcode=0.
REQ-037 During reset, all strobes SHALL be 0 and imm_sel SHALL be 3.
REQ-038 rst SHALL take priority over every transition and retire.

Verification
REQ-039 addi x1,x0,5 (0x00500093) with zero-wait memory: ir_write in cycle 1, imm_sel=0 and alu_src_b=1 in cycles 2-4, reg_write=1 with wb_sel=0 in cycle 4, instret becomes 1.
REQ-040 lw x2,0(x1) (0x0000A103) with 2 wait cycles in MEM: mem_req held 3 cycles in MEM with mem_we=0, reg_write=1 with wb_sel=1, total 7 cycles, instret +1.
REQ-041 sw x2,4(x1) (0x0020A223): imm_sel=1, mem_we=1 only in MEM, reg_write never 1, back to FETCH after 4 cycles.
REQ-042 beq x0,x0,8 (0x00000463): with branch_cond=1, pc_write=1 and pc_src=1 in cycle 3; with branch_cond=0, there is no pc_write in cycle 3; both take 3 cycles.
REQ-043 instr 0xFFFFFFFF: TRAP after DECODE, illegal_instr=1 held for 10 cycles, instret unchanged; rst=1 clears the flag and the next fetch proceeds.
REQ-044 Reset and wrap: rst asserted mid-MEM wait gives FETCH and zeroed outputs on the next edge; instret forced near 0xFFFFFFFF by retiring instructions (or a bench force) wraps to 0x00000000.
